multi_debounce: RTL and testbench

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

---
 rtl/multi_debounce.sv | 101 ++++++++++
 tb/tb_multi_debounce.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multi_debounce.sv
// multi_debounce: per-channel synchronizer + stability-count debouncer.
//   clk        rising-edge system clock
//   rst        asynchronous, active-high reset
//   tick       sample enable for the stability counters
//   din        raw asynchronous inputs, one bit per channel
//   dout       debounced level per channel (registered)
//   rise       one-cycle pulse after dout goes 0->1 (registered)
//   fall       one-cycle pulse after dout goes 1->0 (registered)
//   any_change OR of all rise/fall bits (combinational from registers)
module multi_debounce #(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned STABLE_CNT  = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic [N_CH-1:0] din,
   output logic [N_CH-1:0] dout,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic            any_change
);

   // Final count value at which a new level is accepted.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   logic [SYNC_STAGES-1:0] sync_q [N_CH];
   logic [CNT_W-1:0]       cnt_q  [N_CH];
   logic [CNT_W-1:0]       cnt_d  [N_CH];
   logic [N_CH-1:0]        sync_c;
   logic [N_CH-1:0]        dout_d;
   logic [N_CH-1:0]        rise_d;
   logic [N_CH-1:0]        fall_d;

   // Synchronizer chains; bit 0 takes the raw input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(N_CH); i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(N_CH); i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], din[i]};
         end
      end
   end

   // Last synchronizer stage per channel.
   always_comb begin
      sync_c = '0;
      for (int i = 0; i < N_CH; i++) begin
         sync_c[i] = sync_q[i][SYNC_STAGES-1];
      end
   end

   // Qualification: count ticked disagreements, accept on the last one.
   always_comb begin
      dout_d = dout;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_c[i] == dout[i]) begin
            cnt_d[i] = '0;
         end else if (tick) begin
            if (cnt_q[i] == CNT_LAST) begin
               cnt_d[i]  = '0;
               dout_d[i] = sync_c[i];
               rise_d[i] = sync_c[i];
               fall_d[i] = ~sync_c[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(N_CH); i++) begin
            cnt_q[i] <= '0;
         end
         dout <= '0;
         rise <= '0;
         fall <= '0;
      end else begin
         for (int i = 0; i < int'(N_CH); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         dout <= dout_d;
         rise <= rise_d;
         fall <= fall_d;
      end
   end

   assign any_change = |(rise | fall);

endmodule

// File: tb/tb_multi_debounce.sv
// tb_multi_debounce: checks two multi_debounce instances (defaults, and
// SYNC_STAGES=3/STABLE_CNT=1) against a behavioural model driven by
// directed scenarios followed by random input and tick patterns.
module tb_multi_debounce;

   localparam int unsigned N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         tick;
   logic [N-1:0] din;
   logic [N-1:0] a_dout, a_rise, a_fall;
   logic         a_any;
   logic [N-1:0] b_dout, b_rise, b_fall;
   logic         b_any;

   always #5 clk = ~clk;

   multi_debounce u_a (
      .clk(clk), .rst(rst), .tick(tick), .din(din),
      .dout(a_dout), .rise(a_rise), .fall(a_fall), .any_change(a_any)
   );

   multi_debounce #(.N_CH(4), .SYNC_STAGES(3), .STABLE_CNT(1), .CNT_W(4)) u_b (
      .clk(clk), .rst(rst), .tick(tick), .din(din),
      .dout(b_dout), .rise(b_rise), .fall(b_fall), .any_change(b_any)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: a history of raw samples gives the synchronized view; each
   // channel counts ticked samples that disagree with its accepted level.
   int           stg  [2] = '{2, 3};
   int           stab [2] = '{4, 1};
   logic [N-1:0] hist [2][4];
   int           run  [2][N];
   logic [N-1:0] m_dout [2];
   logic [N-1:0] m_rise [2];
   logic [N-1:0] m_fall [2];

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 4; j++) hist[k][j] = '0;
         for (int c = 0; c < N; c++) run[k][c] = 0;
         m_dout[k] = '0;
         m_rise[k] = '0;
         m_fall[k] = '0;
      end
   endfunction

   function automatic void model_edge(input logic [N-1:0] d, input logic t);
      logic [N-1:0] seen;
      for (int k = 0; k < 2; k++) begin
         // Value the design sees at this edge = raw sample from stg edges ago.
         seen = hist[k][stg[k]-1];
         for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
         hist[k][0] = d;
         m_rise[k] = '0;
         m_fall[k] = '0;
         for (int c = 0; c < N; c++) begin
            if (seen[c] == m_dout[k][c]) begin
               run[k][c] = 0;
            end else if (t) begin
               run[k][c]++;
               if (run[k][c] >= stab[k]) begin
                  run[k][c] = 0;
                  m_dout[k][c] = seen[c];
                  if (seen[c]) m_rise[k][c] = 1'b1;
                  else         m_fall[k][c] = 1'b1;
               end
            end
         end
      end
   endfunction

   task automatic check_all(input string tag);
      check_eq({tag, "_a_dout"}, 32'(a_dout), 32'(m_dout[0]));
      check_eq({tag, "_a_rise"}, 32'(a_rise), 32'(m_rise[0]));
      check_eq({tag, "_a_fall"}, 32'(a_fall), 32'(m_fall[0]));
      check_eq({tag, "_a_any"},  32'(a_any),  32'(|(m_rise[0] | m_fall[0])));
      check_eq({tag, "_b_dout"}, 32'(b_dout), 32'(m_dout[1]));
      check_eq({tag, "_b_rise"}, 32'(b_rise), 32'(m_rise[1]));
      check_eq({tag, "_b_fall"}, 32'(b_fall), 32'(m_fall[1]));
      check_eq({tag, "_b_any"},  32'(b_any),  32'(|(m_rise[1] | m_fall[1])));
      check_eq({tag, "_a_excl"}, 32'(a_rise & a_fall), 32'd0);
   endtask

   // Drive one cycle: inputs applied between edges, outputs sampled #1 after.
   task automatic step(input string tag, input logic [N-1:0] d, input logic t);
      din  = d;
      tick = t;
      @(posedge clk);
      model_edge(d, t);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag, input int cycles);
      rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      repeat (cycles) begin
         @(posedge clk);
         #1;
         check_all(tag);
      end
      rst = 1'b0;
   endtask

   initial begin
      int first_a, first_b, n_any;
      logic [N-1:0] d;
      rst  = 1'b1;
      din  = '0;
      tick = 1'b1;
      model_reset();
      #1;
      check_all("por");
      do_reset("rst0", 2);

      // din[0] rises and holds: latency 6 (defaults) and 4 (3 stages, 1 count).
      first_a = 0;
      first_b = 0;
      for (int e = 1; e <= 10; e++) begin
         step("lat", 4'b0001, 1'b1);
         if (a_dout[0] && first_a == 0) first_a = e;
         if (b_dout[0] && first_b == 0) first_b = e;
      end
      check_eq("lat_a_edges", 32'(first_a), 32'd6);
      check_eq("lat_b_edges", 32'(first_b), 32'd4);

      // Short pulse on din[1] must be rejected by the default instance.
      repeat (3) step("short", 4'b0011, 1'b1);
      repeat (8) step("short", 4'b0001, 1'b1);
      check_eq("short_a_dout1", 32'(a_dout[1]), 32'd0);

      // Sparse tick: din[2] qualifies only on ticked samples.
      for (int i = 0; i < 40; i++) step("sparse", 4'b0101, 1'b1 * (i % 4 == 3));
      check_eq("sparse_a_dout2", 32'(a_dout[2]), 32'd1);

      // Opposite simultaneous transitions on channels 0 and 3.
      repeat (10) step("pre31", 4'b1000, 1'b1);
      n_any = 0;
      for (int i = 0; i < 10; i++) begin
         step("opp", 4'b0001, 1'b1);
         if (a_any) n_any++;
      end
      check_eq("opp_any_cycles", 32'(n_any), 32'd1);

      // Reset in the middle of qualification, then requalify from zero.
      repeat (8) step("pre32", 4'b0000, 1'b1);
      repeat (4) step("mid", 4'b0001, 1'b1);
      do_reset("rst_mid", 2);
      first_a = 0;
      n_any   = 0;
      for (int e = 1; e <= 10; e++) begin
         step("post", 4'b0001, 1'b1);
         if (a_dout[0] && first_a == 0) first_a = e;
         if (a_rise[0]) n_any++;
      end
      check_eq("post_a_edges", 32'(first_a), 32'd6);
      check_eq("post_a_rises", 32'(n_any), 32'd1);

      // Random: sticky inputs with occasional flips/glitches, random tick.
      d = '0;
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(7) == 0) d[c] = ~d[c];
         end
         step("rnd", d, 1'($urandom_range(3) != 0));
         if ($urandom_range(499) == 0) do_reset("rnd_rst", 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
